// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: rising-edge capture of level requests into
// PEND, per-source MASK, and lowest-index-first interrupt ID for the CPU.
module int_ctrl #(
  parameter int          NSRC = 6,
  parameter logic [31:0] BASE = 32'h0000_7f20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic [31:0]     addr,
  input  logic [3:0]      byteen,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [NSRC-1:0] hw_int,
  output logic            int_req,
  output logic [2:0]      int_id
);

  typedef enum logic [1:0] {
    REG_ACK  = 2'd0,
    REG_MASK = 2'd1,
    REG_PEND = 2'd2,
    REG_ID   = 2'd3
  } reg_e;

  localparam logic [29:0] BASE_WORD = BASE[31:2];

  logic [NSRC-1:0] pend_q, mask_q, prev_q;
  logic [29:0]     word_off;
  logic            hit, wr_en;
  reg_e            sel;
  logic [31:0]     lane_mask;
  logic [NSRC-1:0] wr_bits, rise, ack_clr;
  logic            unused_bits;

  // Word offset from BASE; anything past the fourth word (or below BASE, which
  // wraps to a large offset) is outside the window.
  assign word_off  = addr[31:2] - BASE_WORD;
  assign hit       = (word_off < 30'd4);
  assign sel       = reg_e'(word_off[1:0]);
  assign wr_en     = hit && (byteen != 4'b0000);
  assign lane_mask = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
  assign wr_bits   = lane_mask[NSRC-1:0];

  assign rise    = irq_src & ~prev_q;
  assign ack_clr = (wr_en && sel == REG_ACK) ? (wdata[NSRC-1:0] & wr_bits) : '0;

  assign unused_bits = &{1'b0, addr[1:0], wdata[31:NSRC], lane_mask[31:NSRC]};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      mask_q <= '1;
      prev_q <= '0;
    end else begin
      prev_q <= irq_src;
      // Rise is OR-ed in after the clear so a coincident edge is never lost.
      pend_q <= (pend_q & ~ack_clr) | rise;
      if (wr_en && sel == REG_MASK)
        mask_q <= (mask_q & ~wr_bits) | (wdata[NSRC-1:0] & wr_bits);
    end
  end

  assign hw_int  = pend_q & mask_q;
  assign int_req = |hw_int;

  // NOTE: each always_comb assigns its outputs a default first, so no path
  // leaves them unassigned and no latch is inferred.
  always_comb begin
    int_id = 3'd7;
    for (int i = NSRC - 1; i >= 0; i--)
      if (hw_int[i]) int_id = 3'(i);
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (sel)
        REG_MASK: rdata[NSRC-1:0] = mask_q;
        REG_PEND: rdata[NSRC-1:0] = pend_q;
        REG_ID:   rdata[2:0]      = int_id;
        default:  rdata           = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: stimulus queues expected values, a negedge
// monitor pops and compares them against the live DUT outputs.
module tb_int_ctrl;

  localparam int          NSRC = 6;
  localparam logic [31:0] BASE = 32'h0000_7f20;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] irq_src;
  logic [31:0]     addr;
  logic [3:0]      byteen;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic [NSRC-1:0] hw_int;
  logic            int_req;
  logic [2:0]      int_id;

  int_ctrl #(.NSRC(NSRC), .BASE(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_src (irq_src),
    .addr    (addr),
    .byteen  (byteen),
    .wdata   (wdata),
    .rdata   (rdata),
    .hw_int  (hw_int),
    .int_req (int_req),
    .int_id  (int_id)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {SEL_RDATA, SEL_HWINT, SEL_REQ, SEL_ID} sel_e;
  typedef struct {
    string       name;
    sel_e        what;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  // Monitor: everything queued since the last edge is compared mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.what)
        SEL_RDATA: act = rdata;
        SEL_HWINT: act = 32'(hw_int);
        SEL_REQ:   act = 32'(int_req);
        default:   act = 32'(int_id);
      endcase
      checks++;
      if (act === e.exp) passes++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string n, input sel_e w, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.what = w;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic expect_out(input string n, input logic [NSRC-1:0] hw,
                            input logic req, input logic [2:0] id);
    expect_v({n, ".hw_int"},  SEL_HWINT, 32'(hw));
    expect_v({n, ".int_req"}, SEL_REQ,   32'(req));
    expect_v({n, ".int_id"},  SEL_ID,    32'(id));
  endtask

  task automatic rd(input string n, input logic [31:0] a, input logic [31:0] v);
    addr   = a;
    byteen = 4'h0;
    expect_v(n, SEL_RDATA, v);
    sync();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr   = a;
    wdata  = d;
    byteen = be;
    sync();
    byteen = 4'h0;
    wdata  = '0;
  endtask

  task automatic pulse(input logic [NSRC-1:0] v);
    irq_src = v;
    sync();
    irq_src = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; irq_src = '0; addr = BASE; byteen = 4'h0; wdata = '0;
    sync();
    expect_out("reset", 6'h00, 1'b0, 3'd7);
    rd("reset.mask", BASE + 4, 32'h3f);
    reset = 1'b1;
    sync();

    // Single pulse on source 2
    pulse(6'h04);
    expect_out("pulse2", 6'h04, 1'b1, 3'd2);
    rd("pulse2.pend", BASE + 8, 32'h04);
    rd("pulse2.pend_lowbits", BASE + 8 + 3, 32'h04);
    rd("pulse2.id", BASE + 12, 32'h2);

    // ACK while source 2 stays high: no re-set
    irq_src = 6'h04;
    sync();
    wr(BASE, 32'h04, 4'hf);
    expect_out("ack2", 6'h00, 1'b0, 3'd7);
    rd("ack2.pend", BASE + 8, 32'h0);
    rd("ack2.pend_held", BASE + 8, 32'h0);
    irq_src = '0;
    sync();

    // Simultaneous sources 0 and 3: lowest index first
    pulse(6'h09);
    expect_out("dual", 6'h09, 1'b1, 3'd0);
    wr(BASE, 32'h01, 4'hf);
    expect_out("dual.ack0", 6'h08, 1'b1, 3'd3);
    wr(BASE, 32'h08, 4'hf);
    expect_out("dual.ack3", 6'h00, 1'b0, 3'd7);

    // Masking hides but keeps PEND; unmask shows it after the writing edge
    wr(BASE + 4, 32'h3e, 4'hf);
    pulse(6'h01);
    expect_out("masked", 6'h00, 1'b0, 3'd7);
    rd("masked.pend", BASE + 8, 32'h01);
    wr(BASE + 4, 32'h3f, 4'hf);
    expect_out("unmask", 6'h01, 1'b1, 3'd0);
    wr(BASE, 32'h01, 4'hf);
    wr(BASE + 4, 32'h00, 4'he);
    rd("mask.lane_off", BASE + 4, 32'h3f);
    wr(BASE + 4, 32'hffff_ffc0, 4'hf);
    rd("mask.clear", BASE + 4, 32'h00);
    wr(BASE + 4, 32'hffff_ffff, 4'hf);
    rd("mask.upper_zero", BASE + 4, 32'h3f);

    // Rise coincident with ACK: set wins; ACK in a disabled lane is ignored
    addr = BASE; wdata = 32'h02; byteen = 4'hf; irq_src = 6'h02;
    sync();
    byteen = 4'h0;
    rd("setwins.pend", BASE + 8, 32'h02);
    wr(BASE, 32'h02, 4'h2);
    rd("ack_lane.pend", BASE + 8, 32'h02);
    wr(BASE, 32'h02, 4'hf);
    rd("ack1.pend", BASE + 8, 32'h00);
    irq_src = '0;
    sync();

    // PEND and ID are read-only; ACK reads 0
    pulse(6'h04);
    wr(BASE + 8, 32'h0, 4'hf);
    rd("pend_ro", BASE + 8, 32'h04);
    wr(BASE + 12, 32'h0, 4'hf);
    rd("id_ro", BASE + 12, 32'h2);
    rd("ack_reads0", BASE, 32'h0);

    // Asynchronous reset mid-operation
    pulse(6'h01);
    rd("pre_reset.pend", BASE + 8, 32'h05);
    wr(BASE + 4, 32'h00, 4'hf);
    addr = BASE + 8;
    reset = 1'b0;
    #1;
    expect_out("async_rst", 6'h00, 1'b0, 3'd7);
    expect_v("async_rst.pend", SEL_RDATA, 32'h0);
    sync();
    rd("async_rst.mask", BASE + 4, 32'h3f);
    reset = 1'b1;
    sync();

    // Out-of-window accesses
    wr(BASE + 32'h10, 32'hffff_ffff, 4'hf);
    rd("oow.read", BASE + 32'h10, 32'h0);
    wr(BASE - 4, 32'h0, 4'hf);
    rd("below.read", BASE - 4, 32'h0);
    rd("oow.mask", BASE + 4, 32'h3f);
    rd("oow.pend", BASE + 8, 32'h00);

    // Source already high at reset release is captured on the first edge
    reset = 1'b0;
    irq_src = 6'h08;
    sync();
    reset = 1'b1;
    sync();
    expect_out("release_high", 6'h08, 1'b1, 3'd3);
    rd("release_high.pend", BASE + 8, 32'h08);
    irq_src = '0;

    for (int i = 0; i < 10 && q.size() > 0; i++) sync();
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter NSRC, default 6: number of interrupt sources, legal range 1..8.
REQ-002 Parameter BASE, default 32'h0000_7f20: word-aligned base of the 16-byte register window.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port reset  input  1: reset, asynchronous and active-low.
REQ-005 Port irq_src  input  NSRC: level requests from peripherals (timers, external pin); bit i = source i.
REQ-006 Port addr  input  32: CPU data-bus byte address.
REQ-007 Port byteen  input  4: CPU store byte enables; nonzero means write this cycle.
REQ-008 Port wdata  input  32: CPU store data.
REQ-009 Port rdata  output  32: read data for addr, combinational.
REQ-010 Port hw_int  output  NSRC: masked pending vector to CP0 IP field.
REQ-011 Port int_req  output  1: OR of hw_int; drives CPU interrupt input.
REQ-012 Port int_id  output  3: index of lowest-numbered bit set in hw_int; 3'd7 when none.

Function
REQ-013 Register map: BASE+0 ACK (write-only, reads 0); BASE+4 MASK (rw); BASE+8 PEND (ro); BASE+C ID (ro, {29'b0,int_id}).
REQ-014 Decode uses addr[31:2] only; addr[1:0] ignored; addresses outside the window read 0 and ignore writes.
REQ-015 Writes honor byteen per byte lane; bits in disabled lanes are unchanged; only bits [NSRC-1:0] are implemented, others read 0.
REQ-016 Edge detect: prev register holds irq_src from previous cycle; rise_i = irq_src[i] & ~prev[i].
REQ-017 PEND[i] sets on the clock edge where rise_i is 1; a held-high source sets PEND once only.
REQ-018 ACK write: PEND[i] clears on the same clock edge when wdata[i]=1 and its byte lane is enabled; wdata bit 0 leaves PEND[i] unchanged.
REQ-019 Simultaneous rise_i and ACK clear of bit i in one cycle: set wins, PEND[i] remains 1.
REQ-020 Writes to PEND or ID are ignored.
REQ-021 hw_int = PEND & MASK, combinational from registers; int_req and int_id derive combinationally from hw_int.
REQ-022 Latency: irq_src rising before edge k gives PEND and int_req high after edge k (one cycle); ACK write at edge k drops int_req after edge k if no other masked pending bit.
REQ-023 MASK change takes effect on hw_int/int_req immediately after the writing edge; masking does not clear PEND.
REQ-024 Priority: lower index wins in int_id; int_id reports a source until its PEND bit is acknowledged or masked.

Reset
REQ-025 reset low asynchronously forces PEND=0, MASK=all ones, prev=0; hw_int=0, int_req=0, int_id=3'd7 without waiting for clk.
REQ-026 After reset release, a source already high is seen as a rising edge on the first clock edge (prev=0) and sets PEND.
REQ-027 Reset asserted mid-operation discards all pending requests; no ACK is required afterwards.

Verification
REQ-028 Reset low, irq_src=0; release; pulse irq_src[2] one cycle -> after next edge PEND=0x04, int_req=1, int_id=2, rdata@BASE+8=0x04.
REQ-029 PEND=0x04; store wdata=0x04 byteen=4'hf to BASE -> after edge PEND=0, int_req=0, int_id=7; holding irq_src[2] high throughout does not re-set PEND.
REQ-030 irq_src[0] and irq_src[3] rise same cycle -> int_id=0; ACK 0x01 -> int_id=3; ACK 0x08 -> int_req=0.
REQ-031 Store 0x3e to BASE+4, pulse irq_src[0] -> PEND=0x01, int_req=0; store 0x3f to BASE+4 -> int_req=1 immediately after edge.
REQ-032 irq_src[1] rises in same cycle as ACK wdata=0x02 -> PEND[1]=1 after edge; ACK with byteen=4'h2, wdata=0x02 -> PEND unchanged.
REQ-033 PEND=0x05, assert reset low between edges -> int_req=0, PEND=0, MASK=0x3f before next clk edge; store to BASE+0x10 -> no register changes, read returns 0.
